// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, with a byte-serial loader.
//
// Fetch side: a combinational read returns one 32-bit word per byte address,
// so the IF/ID register can capture it on the same edge the PC is presented.
// Load side: a ready/valid byte stream is assembled into little-endian words
// and written sequentially from word 0. An IDLE/LOAD/DONE FSM tracks progress.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   ce_i          : fetch enable (inst_o = 0 when low)
//   addr_i        : fetch byte address (bits [1:0] ignored)
//   inst_o        : fetched instruction (NOP_INST out of range or while loading)
//   ld_start_i    : start/restart a load at word 0 (wins over a same-cycle byte)
//   ld_valid_i    : load byte valid
//   ld_byte_i     : load byte
//   ld_last_i     : marks the current byte as the final byte of the image
//   ld_ready_o    : loader accepts a byte this cycle
//   ld_busy_o     : FSM in LOAD
//   ld_done_o     : FSM in DONE
//   ld_ovf_o      : sticky, image truncated because the array filled up
//   ld_words_o    : words written by the current or last load
module inst_rom_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_ovf_o,
  output logic [ADDR_W:0]   ld_words_o
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            mem_we;
  logic [31:0]     mem_wdata;

  // Array is deliberately not reset: contents survive rst.
  logic [31:0]     mem_q [DEPTH];

  // Byte-lane bits of the fetch address are not used by a word-wide memory.
  logic            unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_o = '0;
    if (ce_i) begin
      if (state_q == S_LOAD || addr_i[31:ADDR_W+2] != '0) begin
        inst_o = NOP_INST;
      end else begin
        inst_o = mem_q[addr_i[ADDR_W+1:2]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  assign ld_ready_o = (state_q == S_LOAD) && (ptr_q < PTR_FULL) && !ld_start_i;
  assign accept     = ld_valid_i && ld_ready_o;
  assign ld_busy_o  = (state_q == S_LOAD);
  assign ld_done_o  = (state_q == S_DONE);
  assign ld_ovf_o   = ovf_q;
  // The word count always equals the write pointer, so it is not stored twice.
  assign ld_words_o = ptr_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    // Unfilled upper lanes of asm_q are always zero, so OR-ing in the new lane
    // yields the zero-padded word a short final word needs.
    mem_wdata = asm_q | (32'(ld_byte_i) << {cnt_q, 3'b000});

    if (ld_start_i) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3 || ld_last_i) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + (ADDR_W + 1)'(1);
        asm_d  = '0;
        if (ld_last_i) begin
          state_d = S_DONE;
        end else if (ptr_d == PTR_FULL) begin
          state_d = S_DONE;
          ovf_d   = 1'b1;
        end
      end else begin
        asm_d = mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Write lands at the clock edge; a same-cycle fetch still sees old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q[ADDR_W-1:0]] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam int SEL_INST  = 0;
  localparam int SEL_READY = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_DONE  = 3;
  localparam int SEL_OVF   = 4;
  localparam int SEL_WORDS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce_i;
  logic [31:0]   addr_i;
  logic [31:0]   inst_o;
  logic          ld_start_i;
  logic          ld_valid_i;
  logic [7:0]    ld_byte_i;
  logic          ld_last_i;
  logic          ld_ready_o;
  logic          ld_busy_o;
  logic          ld_done_o;
  logic          ld_ovf_o;
  logic [AW:0]   ld_words_o;

  inst_rom_loader #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .addr_i     (addr_i),
    .inst_o     (inst_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .ld_busy_o  (ld_busy_o),
    .ld_done_o  (ld_done_o),
    .ld_ovf_o   (ld_ovf_o),
    .ld_words_o (ld_words_o)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   test_finished = 1'b0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_INST:  return inst_o;
      SEL_READY: return 32'(ld_ready_o);
      SEL_BUSY:  return 32'(ld_busy_o);
      SEL_DONE:  return 32'(ld_done_o);
      SEL_OVF:   return 32'(ld_ovf_o);
      default:   return 32'(ld_words_o);
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = observe(e.sel);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic check_now(input string name, input int sel, input logic [31:0] v);
    logic [31:0] act;
    act = observe(sel);
    n_checks++;
    if (act !== v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, v);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    if (!test_finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: test did not finish in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic push(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  int          exp_words;
  bit          exp_ovf;
  bit          exp_done;

  task automatic apply_image(input logic [7:0] b[$], input int last_idx);
    int          n_acc;
    bit          hit_last;
    logic [31:0] w;
    n_acc    = (last_idx >= 0) ? last_idx + 1 : b.size();
    hit_last = (last_idx >= 0);
    if (n_acc > DEPTH * 4) begin
      n_acc    = DEPTH * 4;
      hit_last = 1'b0;
    end
    exp_ovf   = !hit_last && (n_acc == DEPTH * 4);
    exp_done  = hit_last || exp_ovf;
    exp_words = hit_last ? (n_acc + 3) / 4 : n_acc / 4;
    for (int wi = 0; wi < exp_words; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (wi * 4 + k < n_acc) w = w | (32'(b[wi * 4 + k]) << (8 * k));
      end
      mem_m[wi] = w;
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic ce, input logic [31:0] a);
    if (!ce) return '0;
    if (a >= 32'(DEPTH * 4)) return NOP;
    return mem_m[a / 4];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_start();
    ld_start_i = 1'b1;
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'($urandom);
    ld_last_i  = 1'b0;
    push("ready_during_start", SEL_READY, 0);
    tick();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ce_i       = 1'b1;
    addr_i     = 32'($urandom_range(0, DEPTH * 4 - 1));
    push("busy_after_start", SEL_BUSY, 1);
    push("done_after_start", SEL_DONE, 0);
    push("ovf_after_start", SEL_OVF, 0);
    push("words_after_start", SEL_WORDS, 0);
    push("inst_nop_in_load", SEL_INST, NOP);
  endtask

  task automatic load_bytes(input logic [7:0] b[$], input int last_idx);
    int acc = 0;
    bit fin = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid_i = 1'b0;
        tick();
      end
      ld_valid_i = 1'b1;
      ld_byte_i  = b[i];
      ld_last_i  = (i == last_idx);
      addr_i     = 32'($urandom_range(0, DEPTH * 4 - 1));
      push("ready_per_byte", SEL_READY, 32'(!fin && acc < DEPTH * 4));
      if (!fin) push("inst_nop_in_load", SEL_INST, NOP);
      tick();
      if (!fin && acc < DEPTH * 4) begin
        acc++;
        if (i == last_idx || acc == DEPTH * 4) fin = 1'b1;
      end
    end
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    push({tag, "_done"}, SEL_DONE, 32'(exp_done));
    push({tag, "_busy"}, SEL_BUSY, 32'(!exp_done));
    push({tag, "_ovf"}, SEL_OVF, 32'(exp_ovf));
    push({tag, "_words"}, SEL_WORDS, 32'(exp_words));
    if (exp_done) push({tag, "_ready"}, SEL_READY, 0);
  endtask

  task automatic fetch_lit(input string nm, input logic ce, input logic [31:0] a,
                           input logic [31:0] v);
    ce_i   = ce;
    addr_i = a;
    push(nm, SEL_INST, v);
    tick();
  endtask

  task automatic fetch_mdl(input string nm, input logic ce, input logic [31:0] a);
    fetch_lit(nm, ce, a, model_fetch(ce, a));
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [7:0]  bq[$];
    logic [31:0] a;
    int          n;
    int          last_idx;

    rst        = 1'b1;
    ce_i       = 1'b1;
    addr_i     = 32'h40;
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_byte_i  = '0;
    ld_last_i  = 1'b0;
    #2;
    check_now("rst_busy", SEL_BUSY, 0);
    check_now("rst_ready", SEL_READY, 0);
    check_now("rst_words", SEL_WORDS, 0);
    check_now("rst_done", SEL_DONE, 0);
    check_now("rst_ovf", SEL_OVF, 0);
    check_now("rst_inst_oob", SEL_INST, NOP);
    tick();
    rst = 1'b0;
    tick();

    do_start();
    bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    load_bytes(bq, 7);
    apply_image(bq, 7);
    check_status("two_words");
    fetch_lit("fetch_0x0", 1'b1, 32'h0, 32'h0010_0513);
    fetch_lit("fetch_0x5", 1'b1, 32'h5, 32'h0020_0593);

    do_start();
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_bytes(bq, 5);
    apply_image(bq, 5);
    check_status("six_bytes");
    fetch_lit("fetch_w0_six", 1'b1, 32'h0, 32'hDDCC_BBAA);
    fetch_lit("fetch_w1_pad", 1'b1, 32'h4, 32'h0000_2211);

    do_start();
    bq = {};
    for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
    load_bytes(bq, -1);
    apply_image(bq, -1);
    check_status("overflow");
    push("ovf_lit", SEL_OVF, 1);
    push("ovf_words_lit", SEL_WORDS, 4);
    fetch_lit("fetch_oob_0x10", 1'b1, 32'h10, NOP);
    fetch_lit("fetch_ce0", 1'b0, 32'h0, 32'h0);
    for (int w = 0; w < DEPTH; w++) fetch_mdl("fetch_ovf_word", 1'b1, 32'(w * 4));

    do_start();
    bq = '{8'h01, 8'h02};
    load_bytes(bq, -1);
    ld_start_i = 1'b1;
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'hEE;
    push("restart_ready", SEL_READY, 0);
    tick();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    push("restart_words", SEL_WORDS, 0);
    push("restart_busy", SEL_BUSY, 1);
    bq = '{8'h37, 8'h45, 8'h23, 8'h01};
    load_bytes(bq, 3);
    apply_image(bq, 3);
    check_status("after_restart");
    fetch_lit("restart_w0", 1'b1, 32'h0, 32'h0123_4537);

    do_start();
    bq = {};
    for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
    load_bytes(bq, -1);
    apply_image(bq, -1);
    ce_i   = 1'b1;
    addr_i = 32'h0;
    rst    = 1'b1;
    push("arst_busy", SEL_BUSY, 0);
    push("arst_ready", SEL_READY, 0);
    push("arst_done", SEL_DONE, 0);
    push("arst_ovf", SEL_OVF, 0);
    push("arst_words", SEL_WORDS, 0);
    push("arst_inst_w0", SEL_INST, mem_m[0]);
    tick();
    rst = 1'b0;
    fetch_mdl("arst_w1_kept", 1'b1, 32'h4);
    fetch_mdl("arst_w0_again", 1'b1, 32'h3);

    for (int it = 0; it < 8; it++) begin
      do_start();
      bq = {};
      if ($urandom_range(0, 3) == 0) begin
        n        = $urandom_range(16, 20);
        last_idx = -1;
      end else begin
        n        = $urandom_range(1, 16);
        last_idx = n - 1;
      end
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      load_bytes(bq, last_idx);
      apply_image(bq, last_idx);
      check_status("rand");
      for (int w = 0; w < exp_words; w++)
        fetch_mdl("rand_fetch", 1'b1, 32'(w * 4 + $urandom_range(0, 3)));
      a = $urandom;
      if (a < 32'(DEPTH * 4)) a = a + 32'(DEPTH * 4);
      fetch_mdl("rand_oob", 1'b1, a);
      fetch_mdl("rand_ce0", 1'b0, 32'($urandom));
      ld_valid_i = 1'b1;
      ld_byte_i  = 8'($urandom);
      push("idle_ready", SEL_READY, 0);
      tick();
      ld_valid_i = 1'b0;
      push("idle_words_hold", SEL_WORDS, 32'(exp_words));
      push("idle_done_hold", SEL_DONE, 1);
    end

    @(negedge clk);
    #1;
    test_finished = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
